uart_transmitter: RTL

- Serial UART transmitter. It is the counterpart of uart_receiver and uses the same frame and baud_select encoding.
- Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 even-parity bit, 1 stop bit (1).
- Sits between the system-side byte producer and the TxD line.
- In loopback it drives uart_receiver's RxD directly.

---
 rtl/uart_pkg.sv | 62 ++++++
 rtl/baud_controller.sv | 73 +++++++
 rtl/uart_transmitter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both uart_transmitter and uart_receiver:
// frame FSM encoding, oversampling ratio, baud divisor table and parity helper.
package uart_pkg;

  // Sample ticks per bit period; both ends of the link must agree on it.
  localparam int OVERSAMPLE = 32'sd16;

  // Width of the baud divisor counter (holds 20833 at 300 baud / 100 MHz).
  localparam int DIV_W = 32'sd15;

  // Payload width of one frame.
  localparam int DATA_W = 32'sd8;

  // Frame sequencer states, shared with the receiver.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Line rate selected by each baud_select code.
  function automatic int baud_rate(input logic [2:0] sel);
    int rate;
    case (sel)
      3'd0:    rate = 32'sd300;
      3'd1:    rate = 32'sd1200;
      3'd2:    rate = 32'sd4800;
      3'd3:    rate = 32'sd9600;
      3'd4:    rate = 32'sd19200;
      3'd5:    rate = 32'sd38400;
      3'd6:    rate = 32'sd57600;
      3'd7:    rate = 32'sd115200;
      default: rate = 32'sd115200;
    endcase
    return rate;
  endfunction

  // Clocks per sample tick, rounded to nearest: round(clk / (oversample * baud)).
  // Only ever called with constant arguments to build the divisor table.
  function automatic logic [DIV_W-1:0] baud_divisor(input int clk_hz,
                                                    input int oversample,
                                                    input logic [2:0] sel);
    int den;
    int quo;
    den = oversample * baud_rate(sel);
    quo = (clk_hz + (den / 32'sd2)) / den;
    if (quo < 32'sd1) begin
      quo = 32'sd1;
    end else begin
      quo = quo;
    end
    return quo[DIV_W-1:0];
  endfunction

  // Even parity bit: makes the total count of ones across data+parity even.
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Sample-tick generator: emits a one-cycle sample_ENABLE pulse every
// <divisor> clocks, where the divisor is chosen by baud_select. A clear
// restarts the period so the first tick lands exactly one period later.
module baud_controller #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       sample_ENABLE
);

  import uart_pkg::*;

  localparam logic [DIV_W-1:0] DIV_0 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd0);
  localparam logic [DIV_W-1:0] DIV_1 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd1);
  localparam logic [DIV_W-1:0] DIV_2 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd2);
  localparam logic [DIV_W-1:0] DIV_3 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd3);
  localparam logic [DIV_W-1:0] DIV_4 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd4);
  localparam logic [DIV_W-1:0] DIV_5 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd5);
  localparam logic [DIV_W-1:0] DIV_6 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd6);
  localparam logic [DIV_W-1:0] DIV_7 = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd7);

  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] count_next;

  // Look up the divisor for the selected line rate.
  always_comb begin
    divisor = DIV_7;
    case (baud_select)
      3'd0:    divisor = DIV_0;
      3'd1:    divisor = DIV_1;
      3'd2:    divisor = DIV_2;
      3'd3:    divisor = DIV_3;
      3'd4:    divisor = DIV_4;
      3'd5:    divisor = DIV_5;
      3'd6:    divisor = DIV_6;
      3'd7:    divisor = DIV_7;
      default: divisor = DIV_7;
    endcase
  end

  // Next counter value: restart on clear, wrap at the end of each period.
  // The >= guards against a count left over from a larger divisor.
  always_comb begin
    div_last   = divisor - 15'd1;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (count >= div_last) begin
      count_next = '0;
    end else begin
      count_next = count + 15'd1;
    end
  end

  // Register the count and a pulse that is high in the last clock of each period,
  // so a consumer sampling on the next edge sees exactly <divisor> clocks per tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      sample_ENABLE <= 1'b0;
    end else begin
      count         <= count_next;
      sample_ENABLE <= (count_next == div_last);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start, 8 data (LSB first), 1 even-parity, 1 stop bit.
// A write is accepted only when enabled and idle; data and rate are latched
// at accept time, so later changes on Tx_DATA/baud_select do not disturb a frame.
module uart_transmitter #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY
);

  import uart_pkg::*;

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  uart_state_t       state;
  logic [7:0]        shift_reg;
  logic              parity_bit;
  logic [2:0]        bit_idx;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        baud_lat;
  logic [2:0]        baud_eff;
  logic              accept;
  logic              sample_enable;
  logic              bit_done;

  // Decide whether this edge starts a frame and which rate the tick generator uses.
  // On the accept edge the incoming baud_select is used so the very first tick
  // period already runs at the new rate.
  always_comb begin
    accept   = Tx_WR && Tx_EN && !Tx_BUSY && (state == ST_IDLE);
    bit_done = sample_enable && (tick_cnt == TICK_LAST);
    if (accept) begin
      baud_eff = baud_select;
    end else begin
      baud_eff = baud_lat;
    end
  end

  baud_controller #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .OVERSAMPLE  (OVERSAMPLE)
  ) u_baud (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_eff),
    .clear         (accept),
    .sample_ENABLE (sample_enable)
  );

  // Frame sequencer: latches a write, then walks START/DATA/PARITY/STOP,
  // holding each bit for OVERSAMPLE ticks and driving TxD from a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      bit_idx    <= 3'd0;
      tick_cnt   <= '0;
      baud_lat   <= 3'd0;
      TxD        <= 1'b1;
      Tx_BUSY    <= 1'b0;
    end else begin
      // Tick counter runs only inside a frame and restarts at every bit boundary.
      if ((state != ST_IDLE) && sample_enable) begin
        if (bit_done) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end else if (accept) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg  <= Tx_DATA;
            parity_bit <= even_parity(Tx_DATA);
            baud_lat   <= baud_select;
            bit_idx    <= 3'd0;
            state      <= ST_START;
            TxD        <= 1'b0;
            Tx_BUSY    <= 1'b1;
          end else begin
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_done) begin
            state <= ST_DATA;
            TxD   <= shift_reg[0];
          end else begin
            TxD <= 1'b0;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              state <= ST_PARITY;
              TxD   <= parity_bit;
            end else begin
              // Present the next bit; shift_reg[0] always holds data[bit_idx].
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              TxD       <= shift_reg[1];
            end
          end else begin
            TxD <= shift_reg[0];
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            state <= ST_STOP;
            TxD   <= 1'b1;
          end else begin
            TxD <= parity_bit;
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            // Busy drops on the edge the last stop tick is consumed, so a
            // write in the very next cycle starts the following frame.
            state   <= ST_IDLE;
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
          end else begin
            TxD <= 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
